// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-requester memory arbiter: FSM state
// encoding, requester IDs and default bus widths.
package mem_arb_pkg;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_READ  = 2'b01;
  localparam logic [1:0] ST_WRITE = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    READ  = ST_READ,
    WRITE = ST_WRITE
  } state_e;

  localparam logic REQ_IC = 1'b0;
  localparam logic REQ_DC = 1'b1;

  localparam int unsigned DEF_WIDTH  = 128;
  localparam int unsigned DEF_ADDR_W = 32;

endpackage

// File: rtl/arb_pick2.sv
// Two-way winner selection for mem_arbiter.
// MEM_ARB_ROUND_ROBIN_EN: when defined, a simultaneous request goes to the
// requester that did not win last time (ptr_i holds the last winner);
// otherwise DC always beats IC and ptr_i is ignored.
module arb_pick2
  import mem_arb_pkg::*;
(
  input  logic pend_ic_i,
  input  logic pend_dc_i,
  input  logic ptr_i,
  output logic winner_o
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Round-robin choice: alternate on contention, otherwise the lone requester.
  always_comb begin
    winner_o = REQ_IC;
    if (pend_ic_i && pend_dc_i) begin
      winner_o = ~ptr_i;
    end else if (pend_dc_i) begin
      winner_o = REQ_DC;
    end else begin
      winner_o = REQ_IC;
    end
  end
`else
  logic unused_ptr_s;
  assign unused_ptr_s = ptr_i;

  // Fixed priority: DC wins whenever it is pending.
  always_comb begin
    winner_o = REQ_IC;
    if (pend_dc_i) begin
      winner_o = REQ_DC;
    end else begin
      winner_o = REQ_IC;
    end
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Serialises IC and DC cache-line reads/writes onto one memory port.
// Downstream requests are registered; acks are routed back to the owner
// combinationally. MEM_ARB_ROUND_ROBIN_EN selects round-robin arbitration
// (default: fixed DC-over-IC priority).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ic_mem_read_req,
  input  logic [ADDR_W-1:0] ic_mem_read_addr,
  output logic [WIDTH-1:0]  ic_mem_read_data,
  output logic              ic_mem_read_ack,
  input  logic              ic_mem_write_req,
  input  logic [ADDR_W-1:0] ic_mem_write_addr,
  input  logic [WIDTH-1:0]  ic_mem_write_data,
  output logic              ic_mem_write_ack,
  input  logic              dc_mem_read_req,
  input  logic [ADDR_W-1:0] dc_mem_read_addr,
  output logic [WIDTH-1:0]  dc_mem_read_data,
  output logic              dc_mem_read_ack,
  input  logic              dc_mem_write_req,
  input  logic [ADDR_W-1:0] dc_mem_write_addr,
  input  logic [WIDTH-1:0]  dc_mem_write_data,
  output logic              dc_mem_write_ack,
  output logic              mem_read_req,
  output logic [ADDR_W-1:0] mem_read_addr,
  input  logic [WIDTH-1:0]  mem_read_data,
  input  logic              mem_read_ack,
  output logic              mem_write_req,
  output logic [ADDR_W-1:0] mem_write_addr,
  output logic [WIDTH-1:0]  mem_write_data,
  input  logic              mem_write_ack,
  output logic              owner
);

  state_e              state_q, state_d;
  logic                rd_req_q, rd_req_d;
  logic                wr_req_q, wr_req_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [WIDTH-1:0]    wr_data_q, wr_data_d;
  logic                owner_q, owner_d;

  logic                pend_ic_s, pend_dc_s, winner_s, ptr_s;
  logic                win_wr_s;
  logic [ADDR_W-1:0]   win_rd_addr_s, win_wr_addr_s;
  logic [WIDTH-1:0]    win_wr_data_s;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic ptr_q, ptr_d;
  assign ptr_s = ptr_q;
`else
  assign ptr_s = REQ_IC;
`endif

  assign pend_ic_s = ic_mem_read_req | ic_mem_write_req;
  assign pend_dc_s = dc_mem_read_req | dc_mem_write_req;

  arb_pick2 u_pick (
    .pend_ic_i (pend_ic_s),
    .pend_dc_i (pend_dc_s),
    .ptr_i     (ptr_s),
    .winner_o  (winner_s)
  );

  // Winner's request fields; a write beats a read from the same requester.
  assign win_wr_s      = (winner_s == REQ_DC) ? dc_mem_write_req  : ic_mem_write_req;
  assign win_rd_addr_s = (winner_s == REQ_DC) ? dc_mem_read_addr  : ic_mem_read_addr;
  assign win_wr_addr_s = (winner_s == REQ_DC) ? dc_mem_write_addr : ic_mem_write_addr;
  assign win_wr_data_s = (winner_s == REQ_DC) ? dc_mem_write_data : ic_mem_write_data;

  // Next-state logic: grant from IDLE, release on the matching downstream ack.
  always_comb begin
    state_d   = state_q;
    rd_req_d  = rd_req_q;
    wr_req_d  = wr_req_q;
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    owner_d   = owner_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    ptr_d     = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (pend_ic_s || pend_dc_s) begin
          owner_d = winner_s;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          ptr_d   = winner_s;
`endif
          if (win_wr_s) begin
            wr_req_d  = 1'b1;
            wr_addr_d = win_wr_addr_s;
            wr_data_d = win_wr_data_s;
            state_d   = WRITE;
          end else begin
            rd_req_d  = 1'b1;
            rd_addr_d = win_rd_addr_s;
            state_d   = READ;
          end
        end else begin
          state_d = IDLE;
        end
      end
      READ: begin
        if (mem_read_ack) begin
          rd_req_d  = 1'b0;
          rd_addr_d = '0;
          state_d   = IDLE;
        end else begin
          state_d = READ;
        end
      end
      WRITE: begin
        if (mem_write_ack) begin
          wr_req_d  = 1'b0;
          wr_addr_d = '0;
          wr_data_d = '0;
          state_d   = IDLE;
        end else begin
          state_d = WRITE;
        end
      end
      default: begin
        rd_req_d  = 1'b0;
        wr_req_d  = 1'b0;
        rd_addr_d = '0;
        wr_addr_d = '0;
        wr_data_d = '0;
        state_d   = IDLE;
      end
    endcase
  end

  // State and downstream request registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      rd_req_q  <= 1'b0;
      wr_req_q  <= 1'b0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      owner_q   <= REQ_IC;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      ptr_q     <= REQ_IC;
`endif
    end else begin
      state_q   <= state_d;
      rd_req_q  <= rd_req_d;
      wr_req_q  <= wr_req_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      owner_q   <= owner_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      ptr_q     <= ptr_d;
`endif
    end
  end

  assign mem_read_req   = rd_req_q;
  assign mem_read_addr  = rd_addr_q;
  assign mem_write_req  = wr_req_q;
  assign mem_write_addr = wr_addr_q;
  assign mem_write_data = wr_data_q;
  assign owner          = owner_q;

  // Acks reach the owner only, and only for the matching transaction type.
  assign ic_mem_read_ack  = mem_read_ack  & (state_q == READ)  & (owner_q == REQ_IC);
  assign dc_mem_read_ack  = mem_read_ack  & (state_q == READ)  & (owner_q == REQ_DC);
  assign ic_mem_write_ack = mem_write_ack & (state_q == WRITE) & (owner_q == REQ_IC);
  assign dc_mem_write_ack = mem_write_ack & (state_q == WRITE) & (owner_q == REQ_DC);

  assign ic_mem_read_data = mem_read_data;
  assign dc_mem_read_data = mem_read_data;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized
// run against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int WIDTH  = 128;
  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              ic_rd, ic_wr, dc_rd, dc_wr;
  logic [ADDR_W-1:0] ic_ra, ic_wa, dc_ra, dc_wa;
  logic [WIDTH-1:0]  ic_wd, dc_wd;
  logic [WIDTH-1:0]  ic_rdata, dc_rdata;
  logic              ic_rack, dc_rack, ic_wack, dc_wack;
  logic              m_rreq, m_wreq, m_rack, m_wack, own;
  logic [ADDR_W-1:0] m_raddr, m_waddr;
  logic [WIDTH-1:0]  m_rdata, m_wdata;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .ic_mem_read_req(ic_rd), .ic_mem_read_addr(ic_ra), .ic_mem_read_data(ic_rdata),
    .ic_mem_read_ack(ic_rack), .ic_mem_write_req(ic_wr), .ic_mem_write_addr(ic_wa),
    .ic_mem_write_data(ic_wd), .ic_mem_write_ack(ic_wack),
    .dc_mem_read_req(dc_rd), .dc_mem_read_addr(dc_ra), .dc_mem_read_data(dc_rdata),
    .dc_mem_read_ack(dc_rack), .dc_mem_write_req(dc_wr), .dc_mem_write_addr(dc_wa),
    .dc_mem_write_data(dc_wd), .dc_mem_write_ack(dc_wack),
    .mem_read_req(m_rreq), .mem_read_addr(m_raddr), .mem_read_data(m_rdata),
    .mem_read_ack(m_rack), .mem_write_req(m_wreq), .mem_write_addr(m_waddr),
    .mem_write_data(m_wdata), .mem_write_ack(m_wack), .owner(own)
  );

  function automatic logic [WIDTH-1:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ic_rd = 1'b0; ic_wr = 1'b0; dc_rd = 1'b0; dc_wr = 1'b0;
    ic_ra = '0; ic_wa = '0; dc_ra = '0; dc_wa = '0;
    ic_wd = '0; dc_wd = '0;
    m_rack = 1'b0; m_wack = 1'b0; m_rdata = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    m_rack = 1'b1;
    m_wack = 1'b1;
    tick();
    tick();
    n_cmp++;
    if ({m_rreq, m_wreq, own} !== 3'b000) begin
      n_err++; $display("FAIL reset_req_owner got %b exp 000", {m_rreq, m_wreq, own});
    end
    n_cmp++;
    if ({m_raddr, m_waddr, m_wdata} !== '0) begin
      n_err++; $display("FAIL reset_addr_data got %h/%h/%h exp 0", m_raddr, m_waddr, m_wdata);
    end
    n_cmp++;
    if ({ic_rack, dc_rack, ic_wack, dc_wack} !== 4'b0000) begin
      n_err++; $display("FAIL reset_acks got %b exp 0000", {ic_rack, dc_rack, ic_wack, dc_wack});
    end
    m_rack = 1'b0;
    m_wack = 1'b0;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_read();
    logic [WIDTH-1:0] d;
    do_reset();
    ic_rd = 1'b1;
    ic_ra = 32'h0000_1230;
    tick();
    n_cmp++;
    if ({m_rreq, m_wreq, own} !== 3'b100 || m_raddr !== 32'h0000_1230) begin
      n_err++; $display("FAIL sr_grant got req %b addr %h exp 100 00001230", {m_rreq, m_wreq, own}, m_raddr);
    end
    tick();
    tick();
    d = rnd_line();
    m_rdata = d;
    m_rack = 1'b1;
    #1;
    n_cmp++;
    if ({ic_rack, dc_rack} !== 2'b10) begin
      n_err++; $display("FAIL sr_ack got %b exp 10", {ic_rack, dc_rack});
    end
    n_cmp++;
    if (ic_rdata !== d) begin
      n_err++; $display("FAIL sr_data got %h exp %h", ic_rdata, d);
    end
    @(posedge clk); #1;
    m_rack = 1'b0;
    ic_rd = 1'b0;
    n_cmp++;
    if (m_rreq !== 1'b0 || m_raddr !== '0) begin
      n_err++; $display("FAIL sr_drop got %b %h exp 0 0", m_rreq, m_raddr);
    end
    tick();
    n_cmp++;
    if ({m_rreq, m_wreq} !== 2'b00) begin
      n_err++; $display("FAIL sr_idle got %b exp 00", {m_rreq, m_wreq});
    end
  endtask

  task automatic test_evict_then_refill();
    logic [WIDTH-1:0] d;
    do_reset();
    d = rnd_line();
    dc_wr = 1'b1; dc_wa = 32'h0000_2000; dc_wd = d;
    dc_rd = 1'b1; dc_ra = 32'h0000_3000;
    tick();
    n_cmp++;
    if ({m_rreq, m_wreq, own} !== 3'b011 || m_waddr !== 32'h0000_2000 || m_wdata !== d) begin
      n_err++; $display("FAIL ev_write got %b %h exp 011 00002000", {m_rreq, m_wreq, own}, m_waddr);
    end
    m_wack = 1'b1;
    #1;
    n_cmp++;
    if ({ic_wack, dc_wack, ic_rack, dc_rack} !== 4'b0100) begin
      n_err++; $display("FAIL ev_wack got %b exp 0100", {ic_wack, dc_wack, ic_rack, dc_rack});
    end
    @(posedge clk); #1;
    m_wack = 1'b0;
    dc_wr = 1'b0;
    n_cmp++;
    if ({m_rreq, m_wreq} !== 2'b00) begin
      n_err++; $display("FAIL ev_idle_gap got %b exp 00", {m_rreq, m_wreq});
    end
    tick();
    n_cmp++;
    if ({m_rreq, m_wreq, own} !== 3'b101 || m_raddr !== 32'h0000_3000) begin
      n_err++; $display("FAIL ev_refill got %b %h exp 101 00003000", {m_rreq, m_wreq, own}, m_raddr);
    end
    m_rack = 1'b1;
    #1;
    n_cmp++;
    if ({ic_rack, dc_rack} !== 2'b01) begin
      n_err++; $display("FAIL ev_rack got %b exp 01", {ic_rack, dc_rack});
    end
    @(posedge clk); #1;
    m_rack = 1'b0;
    dc_rd = 1'b0;
    tick();
  endtask

  task automatic test_contention();
    logic last_w, exp_w;
    do_reset();
    ic_rd = 1'b1; ic_ra = 32'h0000_1100;
    dc_rd = 1'b1; dc_ra = 32'h0000_2200;
    last_w = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
`ifdef MEM_ARB_ROUND_ROBIN_EN
      exp_w = ~last_w;
`else
      exp_w = 1'b1;
`endif
      last_w = exp_w;
      n_cmp++;
      if (m_rreq !== 1'b1 || own !== exp_w || m_raddr !== (exp_w ? 32'h0000_2200 : 32'h0000_1100)) begin
        n_err++; $display("FAIL cont_grant%0d got req %b own %b addr %h exp own %b", i, m_rreq, own, m_raddr, exp_w);
      end
      m_rack = 1'b1;
      #1;
      n_cmp++;
      if ({ic_rack, dc_rack} !== (exp_w ? 2'b01 : 2'b10)) begin
        n_err++; $display("FAIL cont_ack%0d got %b exp own %b", i, {ic_rack, dc_rack}, exp_w);
      end
      @(posedge clk); #1;
      m_rack = 1'b0;
    end
    ic_rd = 1'b0;
    dc_rd = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_spurious_acks();
    do_reset();
    m_rack = 1'b1;
    #1;
    n_cmp++;
    if ({ic_rack, dc_rack, ic_wack, dc_wack} !== 4'b0000) begin
      n_err++; $display("FAIL sp_idle_ack got %b exp 0000", {ic_rack, dc_rack, ic_wack, dc_wack});
    end
    tick();
    m_rack = 1'b0;
    n_cmp++;
    if ({m_rreq, m_wreq} !== 2'b00) begin
      n_err++; $display("FAIL sp_idle_state got %b exp 00", {m_rreq, m_wreq});
    end
    ic_rd = 1'b1; ic_ra = 32'h0000_4440;
    tick();
    m_wack = 1'b1;
    #1;
    n_cmp++;
    if ({ic_rack, dc_rack, ic_wack, dc_wack} !== 4'b0000) begin
      n_err++; $display("FAIL sp_wrong_ack got %b exp 0000", {ic_rack, dc_rack, ic_wack, dc_wack});
    end
    tick();
    m_wack = 1'b0;
    n_cmp++;
    if (m_rreq !== 1'b1 || m_raddr !== 32'h0000_4440) begin
      n_err++; $display("FAIL sp_still_read got %b %h exp 1 00004440", m_rreq, m_raddr);
    end
    m_rack = 1'b1;
    @(posedge clk); #1;
    m_rack = 1'b0;
    ic_rd = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    ic_rd = 1'b1; ic_ra = 32'h0000_5550;
    tick();
    tick();
    reset = 1'b1;
    tick();
    n_cmp++;
    if ({m_rreq, m_wreq, own} !== 3'b000 || m_raddr !== '0) begin
      n_err++; $display("FAIL rm_abandon got %b %h exp 000 0", {m_rreq, m_wreq, own}, m_raddr);
    end
    reset = 1'b0;
    tick();
    n_cmp++;
    if (m_rreq !== 1'b1 || m_raddr !== 32'h0000_5550 || own !== 1'b0) begin
      n_err++; $display("FAIL rm_regrant got %b %h own %b exp 1 00005550 0", m_rreq, m_raddr, own);
    end
    m_rack = 1'b1;
    @(posedge clk); #1;
    m_rack = 1'b0;
    ic_rd = 1'b0;
    tick();
  endtask

  task automatic test_random();
    logic              mb, mwr, mown, mlast, good, w, drop, drop_who, drop_wr;
    logic [ADDR_W-1:0] maddr;
    logic [WIDTH-1:0]  mdata;
    logic [3:0]        exp_ack;
    int                lat;
    do_reset();
    mb = 1'b0; mwr = 1'b0; mown = 1'b0; mlast = 1'b0; lat = 0;
    maddr = '0; mdata = '0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      n_cmp++;
      if ({m_rreq, m_wreq} !== {mb && !mwr, mb && mwr}) begin
        n_err++; $display("FAIL rnd_req cyc %0d got %b exp %b", cyc, {m_rreq, m_wreq}, {mb && !mwr, mb && mwr});
      end
      n_cmp++;
      if (m_raddr !== ((mb && !mwr) ? maddr : '0) || m_waddr !== ((mb && mwr) ? maddr : '0)) begin
        n_err++; $display("FAIL rnd_addr cyc %0d got %h/%h exp %h", cyc, m_raddr, m_waddr, maddr);
      end
      n_cmp++;
      if (m_wdata !== ((mb && mwr) ? mdata : '0)) begin
        n_err++; $display("FAIL rnd_wdata cyc %0d got %h exp %h", cyc, m_wdata, mdata);
      end
      if (mb) begin
        n_cmp++;
        if (own !== mown) begin
          n_err++; $display("FAIL rnd_owner cyc %0d got %b exp %b", cyc, own, mown);
        end
      end
      // downstream memory behaviour, including stray acks
      m_rack = 1'b0; m_wack = 1'b0; good = 1'b0;
      m_rdata = rnd_line();
      if (mb) begin
        if (lat == 0) begin
          good = 1'b1;
          if (mwr) m_wack = 1'b1; else m_rack = 1'b1;
        end else begin
          lat--;
          if ($urandom_range(0, 3) == 0) begin
            if (mwr) m_rack = 1'b1; else m_wack = 1'b1;
          end
        end
      end else if ($urandom_range(0, 3) == 0) begin
        m_rack = 1'($urandom_range(0, 1));
        m_wack = 1'($urandom_range(0, 1));
      end
      #1;
      exp_ack = {good && !mwr && !mown, good && !mwr && mown, good && mwr && !mown, good && mwr && mown};
      n_cmp++;
      if ({ic_rack, dc_rack, ic_wack, dc_wack} !== exp_ack) begin
        n_err++; $display("FAIL rnd_acks cyc %0d got %b exp %b", cyc, {ic_rack, dc_rack, ic_wack, dc_wack}, exp_ack);
      end
      n_cmp++;
      if (ic_rdata !== m_rdata || dc_rdata !== m_rdata) begin
        n_err++; $display("FAIL rnd_rdata cyc %0d got %h/%h exp %h", cyc, ic_rdata, dc_rdata, m_rdata);
      end
      @(posedge clk);
      drop = 1'b0; drop_who = 1'b0; drop_wr = 1'b0;
      if (mb) begin
        if (good) begin
          mb = 1'b0; drop = 1'b1; drop_who = mown; drop_wr = mwr;
        end
      end else if (ic_rd || ic_wr || dc_rd || dc_wr) begin
        if ((ic_rd || ic_wr) && (dc_rd || dc_wr)) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
          w = ~mlast;
`else
          w = 1'b1;
`endif
        end else begin
          w = dc_rd || dc_wr;
        end
        mb = 1'b1; mown = w; mlast = w;
        mwr = w ? dc_wr : ic_wr;
        maddr = w ? (mwr ? dc_wa : dc_ra) : (mwr ? ic_wa : ic_ra);
        mdata = w ? dc_wd : ic_wd;
        lat = $urandom_range(0, 3);
      end
      #1;
      // requesters: drop the acked request, occasionally issue new ones
      if (drop) begin
        if (drop_who) begin
          if (drop_wr) dc_wr = 1'b0; else dc_rd = 1'b0;
        end else begin
          if (drop_wr) ic_wr = 1'b0; else ic_rd = 1'b0;
        end
      end
      if (!ic_rd && !ic_wr && $urandom_range(0, 2) == 0) begin
        ic_rd = 1'($urandom_range(0, 1)); ic_wr = ~ic_rd | 1'($urandom_range(0, 1));
        ic_ra = $urandom; ic_wa = $urandom; ic_wd = rnd_line();
      end
      if (!dc_rd && !dc_wr && $urandom_range(0, 2) == 0) begin
        dc_rd = 1'($urandom_range(0, 1)); dc_wr = ~dc_rd | 1'($urandom_range(0, 1));
        dc_ra = $urandom; dc_wa = $urandom; dc_wd = rnd_line();
      end
    end
    clear_inputs();
    do_reset();
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_single_read();
    test_evict_then_refill();
    test_contention();
    test_spurious_acks();
    test_reset_mid_read();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter sharing the single backing-memory port between the instruction cache (`ic_`) and the data cache (`dc_`). Each side connects to the arbiter exactly as it would connect to memory: level read/write requests held until a one-cycle ack. The arbiter serialises transactions, registers the downstream request, and routes acks and read data back to the owning cache. It sits between the two cache instances and the memory model or controller.

## Interface
- `WIDTH`, 128, cache-line width in bits; data bus width.
- `ADDR_W`, 32, address width.
- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `ic_mem_read_req`, `dc_mem_read_req`  in  1  requester read request; level, held until ack.
- `ic_mem_read_addr`, `dc_mem_read_addr`  in  ADDR_W  line-aligned read address.
- `ic_mem_read_data`, `dc_mem_read_data`  out  WIDTH  both driven directly by `mem_read_data`.
- `ic_mem_read_ack`, `dc_mem_read_ack`  out  1  `mem_read_ack` gated to the current read owner.
- `ic_mem_write_req`, `dc_mem_write_req`  in  1  requester write (evict) request; level, held until ack.
- `ic_mem_write_addr`, `dc_mem_write_addr`  in  ADDR_W  write address.
- `ic_mem_write_data`, `dc_mem_write_data`  in  WIDTH  write line.
- `ic_mem_write_ack`, `dc_mem_write_ack`  out  1  `mem_write_ack` gated to the current write owner.
- `mem_read_req`  out  1  registered downstream read request.
- `mem_read_addr`  out  ADDR_W  registered.
- `mem_read_data`  in  WIDTH  downstream read data.
- `mem_read_ack`  in  1  one-cycle downstream read ack.
- `mem_write_req`  out  1  registered downstream write request.
- `mem_write_addr`  out  ADDR_W  registered.
- `mem_write_data`  out  WIDTH  registered.
- `mem_write_ack`  in  1  one-cycle downstream write ack.
- `owner`  out  1  0 = IC, 1 = DC; valid while the FSM is not IDLE.

## Operation
- FSM states and encoding:
  - IDLE=2'b00: no transaction outstanding.
  - READ=2'b01: downstream read outstanding.
  - WRITE=2'b10: downstream write outstanding.
- A requester is pending when its `read_req | write_req` is high. If both are high on the same requester, the write is issued first, so an eviction precedes its refill.
- IDLE with at least one pending requester:
  - Pick a winner (see Configuration).
  - Latch the winner's addr (and data for a write) into the `mem_*` registers.
  - Set the matching `mem_*_req`, set `owner`, and go to READ or WRITE.
- READ/WRITE:
  - The matching downstream ack is forwarded combinationally, the same cycle, to the owner only.
  - On that ack edge: clear `mem_*_req`, zero the addr/data registers, return to IDLE.
- Grant is released after every ack. A follow-up read after an eviction re-arbitrates.
- Ignored inputs:
  - Acks received in IDLE.
  - The wrong-type ack (a read ack in WRITE, or a write ack in READ).
  - Requests that change while not in IDLE. The latched values are used.
- Reset:
  - Reset values: state IDLE, all `mem_*` outputs 0, `owner` 0, priority pointer 0.
  - Gated acks are 0 after reset.
  - Reset mid-transaction abandons it. Memory must be reset in the same cycle.

## Timing
- Pending requester seen in IDLE in cycle N → `mem_*_req` high in N+1.
- Downstream ack in cycle M → owner ack in M. `mem_*_req` low and state IDLE in M+1. The next grant can be issued in M+2 at the earliest, i.e. one idle cycle between transactions.
- An owner must drop its request by the edge after its ack. A request still high in M+1 is treated as a new transaction.
- Ack and a new request in the same cycle: the new request is sampled only once the FSM is in IDLE.
- Minimum transaction length is 2 cycles (grant edge, then ack cycle).

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined:
  - A 1-bit pointer holds the last winner.
  - On a simultaneous request, the requester that did not win last time is granted.
  - The pointer updates on each grant.
- Undefined: fixed priority, DC always beats IC, and there is no pointer register.

## Structure
- Package `mem_arb_pkg` holds:
  - the state encoding localparams;
  - the requester IDs `REQ_IC=1'b0` and `REQ_DC=1'b1`;
  - the default `WIDTH`/`ADDR_W`.
- One sub-module, `arb_pick2`, is combinational: it takes two pending bits and the pointer and returns the winner ID. Its round-robin logic is compiled under the macro.
- The FSM, the latched downstream registers and the ack gating live in `mem_arbiter`.

## Test plan
- Single IC read of 0x00001230 → `mem_read_req=1`, addr 0x00001230 one cycle later; ack after 3 cycles → `ic_mem_read_ack` pulses that cycle, `dc_mem_read_ack` stays 0, request drops the next cycle.
- DC write 0x00002000 and DC read 0x00003000 asserted together → the write is issued first; after its ack, one idle cycle, then the read issues.
- IC and DC both request reads every cycle, each acked in 2 cycles:
  - with the macro defined, owners alternate IC/DC;
  - without it, DC wins every arbitration.
- Spurious `mem_read_ack` in IDLE and `mem_write_ack` during READ → no requester ack, state unchanged.
- `reset` asserted in the middle of READ → next cycle: state IDLE, all `mem_*` outputs 0; the IC request still high is granted one cycle after `reset` drops.
